bht_gshare: RTL and testbench

- Parametrised gshare branch history table for the CVA6 frontend; successor to the fixed bimodal BHT selected by BPType BHT.
- Indexes saturating counters by fetch PC XOR global branch history.
- Supports configurable entries, history length, counter width and predictions per fetch.
- Includes a sequential row-by-row flush engine.

---
 rtl/bht_gshare.sv | 241 ++++++++++++++++++++++++
 tb/tb_bht_gshare.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_gshare.sv
// -----------------------------------------------------------------------------
// bht_gshare
//   Gshare branch history table for the frontend. Each row holds one saturating
//   counter (plus a valid bit) per 16-bit fetch slot. The row is chosen by the
//   fetch PC XOR the global history register (GHR). With HIST_LEN == 0 the GHR
//   disappears and the table degenerates to a plain bimodal predictor.
//
//   Prediction is combinational from vpc_i; training is registered. A flush
//   request walks the table one row per cycle and clears it; while flushing,
//   predictions read as invalid and training is dropped.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_bht_i          start (or restart) a full-table flush
//   debug_mode_i         high: training updates are ignored
//   vpc_i                fetch PC used for prediction
//   bht_valid_o[s]       slot s maps to a trained entry
//   bht_taken_o[s]       slot s predicted taken (counter MSB)
//   bht_hist_o           GHR used for this prediction; returned on update
//   bht_update_*         resolved conditional branch (pc, direction, history)
//   flush_busy_o         flush engine active
//
// Configuration macro
//   BHT_UPDATE_BYPASS_EN  when defined, an update accepted this cycle that hits
//                         the predicted row/column is forwarded to the
//                         prediction outputs in the same cycle. Undefined
//                         (default): predictions show the pre-update value.
// -----------------------------------------------------------------------------
module bht_gshare #(
  parameter int unsigned NR_ENTRIES      = 128,
  parameter int unsigned HIST_LEN        = 3,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned VLEN            = 64,
  localparam int unsigned HW             = (HIST_LEN > 0) ? HIST_LEN : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bht_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  output logic [INSTR_PER_FETCH-1:0] bht_valid_o,
  output logic [INSTR_PER_FETCH-1:0] bht_taken_o,
  output logic [HW-1:0]              bht_hist_o,
  input  logic                       bht_update_valid_i,
  input  logic [VLEN-1:0]            bht_update_pc_i,
  input  logic                       bht_update_taken_i,
  input  logic [HW-1:0]              bht_update_hist_i,
  output logic                       flush_busy_o
);

  localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned IDX     = $clog2(NR_ROWS);
  localparam int unsigned COL     = $clog2(INSTR_PER_FETCH);
  localparam int unsigned IW      = (IDX > 0) ? IDX : 1;
  localparam int unsigned CW      = (COL > 0) ? COL : 1;

  // Weakly-taken / weakly-not-taken starting points for a freshly trained entry.
  localparam logic [CTR_BITS-1:0] CTR_HALF    = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_HALF - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO    = '0;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e        state_reg, state_next;
  logic [IW-1:0] row_cnt_reg, row_cnt_next;
  logic          flush_row;   // clear row row_cnt_reg at the coming edge
  logic          ghr_clear;
  logic          upd_accept;

  logic [HW-1:0] ghr;
  logic [HW-1:0] upd_hist;

  logic [INSTR_PER_FETCH-1:0] valid_reg [NR_ROWS];
  logic [CTR_BITS-1:0]        ctr_reg   [NR_ROWS][INSTR_PER_FETCH];

  logic [IW-1:0]       pred_row, upd_row;
  logic [CW-1:0]       upd_col;
  logic                upd_entry_valid;
  logic [CTR_BITS-1:0] upd_ctr_old, upd_ctr_new;

  // Only the index/column bits of the PCs are consumed.
  logic [2*VLEN-1:0] unused_pc_bits;
  assign unused_pc_bits = {vpc_i, bht_update_pc_i};

  // ---------------------------------------------------------------------------
  // Global history register
  // ---------------------------------------------------------------------------
  if (HIST_LEN > 0) begin : g_ghr
    logic [HIST_LEN-1:0] ghr_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ghr_reg <= '0;
      end else if (ghr_clear) begin
        ghr_reg <= '0;
      end else if (upd_accept) begin
        // Truncating the concatenation keeps the low HIST_LEN bits, i.e. a
        // left shift with the new outcome in bit 0 (also correct for length 1).
        ghr_reg <= HIST_LEN'({ghr_reg, bht_update_taken_i});
      end
    end

    assign ghr      = ghr_reg;
    assign upd_hist = bht_update_hist_i;
  end else begin : g_no_ghr
    logic [HW-1:0] unused_hist;
    assign unused_hist = bht_update_hist_i;
    assign ghr         = '0;
    assign upd_hist    = '0;
  end

  // ---------------------------------------------------------------------------
  // Index computation (history is zero-extended into the row index)
  // ---------------------------------------------------------------------------
  if (IDX > 0) begin : g_idx
    assign pred_row = vpc_i[COL+1 +: IW] ^ IW'(ghr);
    assign upd_row  = bht_update_pc_i[COL+1 +: IW] ^ IW'(upd_hist);
  end else begin : g_no_idx
    assign pred_row = '0;
    assign upd_row  = '0;
  end

  if (COL > 0) begin : g_col
    assign upd_col = bht_update_pc_i[1 +: CW];
  end else begin : g_no_col
    assign upd_col = '0;
  end

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    flush_row    = 1'b0;
    ghr_clear    = 1'b0;
    upd_accept   = 1'b0;
    flush_busy_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush_bht_i) begin
          // An update arriving with the flush request is dropped.
          state_next   = FLUSH;
          row_cnt_next = '0;
          ghr_clear    = 1'b1;
        end else begin
          upd_accept = bht_update_valid_i && !debug_mode_i;
        end
      end
      FLUSH: begin
        flush_busy_o = 1'b1;
        flush_row    = 1'b1;
        if (flush_bht_i) begin
          row_cnt_next = '0;
          ghr_clear    = 1'b1;
        end else if (row_cnt_reg == IW'(NR_ROWS - 1)) begin
          state_next = IDLE;
        end else begin
          row_cnt_next = row_cnt_reg + IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter update value
  // ---------------------------------------------------------------------------
  always_comb begin
    upd_entry_valid = valid_reg[upd_row][upd_col];
    upd_ctr_old     = ctr_reg[upd_row][upd_col];
    upd_ctr_new     = upd_ctr_old;
    if (!upd_entry_valid) begin
      upd_ctr_new = bht_update_taken_i ? CTR_HALF : CTR_WEAK_NT;
    end else if (bht_update_taken_i) begin
      if (upd_ctr_old != CTR_MAX) upd_ctr_new = upd_ctr_old + CTR_BITS'(1);
    end else begin
      if (upd_ctr_old != CTR_ZERO) upd_ctr_new = upd_ctr_old - CTR_BITS'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Table storage (flops so a whole row can be cleared per cycle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR_ROWS; r++) begin
        valid_reg[r] <= '0;
        for (int c = 0; c < INSTR_PER_FETCH; c++) begin
          ctr_reg[r][c] <= '0;
        end
      end
    end else if (flush_row) begin
      valid_reg[row_cnt_reg] <= '0;
      for (int c = 0; c < INSTR_PER_FETCH; c++) begin
        ctr_reg[row_cnt_reg][c] <= '0;
      end
    end else if (upd_accept) begin
      valid_reg[upd_row][upd_col] <= 1'b1;
      ctr_reg[upd_row][upd_col]   <= upd_ctr_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction, one slot per 16-bit parcel
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot
    logic slot_valid;
    logic slot_taken;

    always_comb begin
      slot_valid = valid_reg[pred_row][gi];
      slot_taken = ctr_reg[pred_row][gi][CTR_BITS-1];
`ifdef BHT_UPDATE_BYPASS_EN
      // Forward on the full row index (history included), not just the PC.
      if (upd_accept && (upd_row == pred_row) && (upd_col == CW'(gi))) begin
        slot_valid = 1'b1;
        slot_taken = upd_ctr_new[CTR_BITS-1];
      end
`endif
    end

    assign bht_valid_o[gi] = slot_valid && (state_reg == IDLE);
    assign bht_taken_o[gi] = slot_taken;
  end

  assign bht_hist_o = ghr;

endmodule

// File: tb/tb_bht_gshare.sv
// -----------------------------------------------------------------------------
// tb_bht_gshare
//   Bench for bht_gshare at default parameters. A table model (arrays of
//   valid/counter values plus a flush countdown) predicts every output on every
//   cycle; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bht_gshare;

  localparam int NR_ROWS = 64;
  localparam int NR_ENT  = 128;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_bht;
  logic        debug_mode;
  logic [63:0] vpc;
  logic [1:0]  bht_valid;
  logic [1:0]  bht_taken;
  logic [2:0]  bht_hist;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [2:0]  upd_hist;
  logic        flush_busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_valid [NR_ENT];
  int m_ctr   [NR_ENT];
  int m_ghr;
  int flush_left;

  always #5 clk = ~clk;

  bht_gshare dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_bht_i        (flush_bht),
    .debug_mode_i       (debug_mode),
    .vpc_i              (vpc),
    .bht_valid_o        (bht_valid),
    .bht_taken_o        (bht_taken),
    .bht_hist_o         (bht_hist),
    .bht_update_valid_i (upd_valid),
    .bht_update_pc_i    (upd_pc),
    .bht_update_taken_i (upd_taken),
    .bht_update_hist_i  (upd_hist),
    .flush_busy_o       (flush_busy)
  );

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic int row_of(logic [63:0] pc, int h);
    return int'(pc[7:2]) ^ h;
  endfunction

  // 2-bit saturating counter rule
  function automatic int post_ctr(int v, int c, logic t);
    if (v == 0) return t ? 2 : 1;
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR_ENT; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_ghr = 0;
  endtask

  // Compare all outputs with the model, mid-cycle.
  task automatic sample();
    int  row, e, ev, et;
    bit  busy;
`ifdef BHT_UPDATE_BYPASS_EN
    int  ur, uc;
    bit  acc;
`endif
    @(negedge clk);
    busy = (flush_left > 0);
    row  = row_of(vpc, m_ghr);
    check("busy", int'(flush_busy), int'(busy));
    check("hist", int'(bht_hist), m_ghr);
`ifdef BHT_UPDATE_BYPASS_EN
    acc = upd_valid && !debug_mode && !busy && !flush_bht;
    ur  = row_of(upd_pc, int'(upd_hist));
    uc  = int'(upd_pc[1]);
`endif
    for (int c = 0; c < 2; c++) begin
      e  = row * 2 + c;
      ev = busy ? 0 : m_valid[e];
      et = (m_ctr[e] >= 2) ? 1 : 0;
`ifdef BHT_UPDATE_BYPASS_EN
      if (acc && ur == row && uc == c) begin
        ev = 1;
        et = (post_ctr(m_valid[ur*2+uc], m_ctr[ur*2+uc], upd_taken) >= 2) ? 1 : 0;
      end
`endif
      check("pred_valid", int'(bht_valid[c[0]]), ev);
      if (!busy) check("pred_taken", int'(bht_taken[c[0]]), et);
    end
  endtask

  // Advance the model across the clock edge.
  task automatic advance();
    int e;
    @(posedge clk);
    if (flush_bht) begin
      model_clear();
      flush_left = NR_ROWS;
    end else if (flush_left > 0) begin
      flush_left--;
    end else if (upd_valid && !debug_mode) begin
      e = row_of(upd_pc, int'(upd_hist)) * 2 + int'(upd_pc[1]);
      m_ctr[e]   = post_ctr(m_valid[e], m_ctr[e], upd_taken);
      m_valid[e] = 1;
      m_ghr      = ((m_ghr << 1) | int'(upd_taken)) & 7;
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    int cnt;
    rst_ni     = 1'b0;
    flush_bht  = 1'b0;
    debug_mode = 1'b0;
    vpc        = 64'h8000_0000;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_hist   = '0;
    model_clear();
    flush_left = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Reset state
    sample();
    check("reset_valid", int'(bht_valid), 0);
    check("reset_taken", int'(bht_taken), 0);
    check("reset_hist", int'(bht_hist), 0);
    check("reset_busy", int'(flush_busy), 0);
    advance();

    // Train row 2 col 0 twice taken: 10 -> 11, ghr 011
    upd_valid = 1'b1; upd_pc = 64'h8000_0004; upd_hist = 3'b011; upd_taken = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    vpc = 64'h8000_0004;
    sample();
    check("train_valid0", int'(bht_valid[0]), 1);
    check("train_taken0", int'(bht_taken[0]), 1);
    check("train_hist", int'(bht_hist), 3);
    advance();

    // Saturation down: 11 -> 10 -> 01 (ghr 110 -> 100)
    upd_valid = 1'b1; upd_taken = 1'b0;
    step();
    step();
    upd_valid = 1'b0;
    vpc = 64'h8000_0018;          // 6 ^ 3'b100 = row 2
    sample();
    check("sat_valid0", int'(bht_valid[0]), 1);
    check("sat_taken0_after2", int'(bht_taken[0]), 0);
    check("sat_hist", int'(bht_hist), 4);
    advance();
    // 01 -> 00 -> 00 (ghr -> 000); an underflow would wrap to 11
    upd_valid = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    vpc = 64'h8000_0008;          // 2 ^ 0 = row 2
    sample();
    check("sat_valid0_floor", int'(bht_valid[0]), 1);
    check("sat_taken0_floor", int'(bht_taken[0]), 0);
    advance();

    // Flush: 64 busy cycles, an update at busy cycle 20 is dropped
    flush_bht = 1'b1;
    step();
    flush_bht = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      upd_valid = (i == 20); upd_pc = 64'h8000_0008; upd_hist = 3'b000; upd_taken = 1'b1;
      sample();
      if (flush_busy) cnt++;
      advance();
    end
    upd_valid = 1'b0;
    check("flush_len", cnt, 64);
    vpc = 64'h8000_0008;
    sample();
    check("flush_cleared_valid0", int'(bht_valid[0]), 0);
    check("flush_ghr", int'(bht_hist), 0);
    advance();

    // Same-cycle hazard on an untrained entry
    upd_valid = 1'b1; upd_pc = 64'h8000_0010; upd_hist = 3'b000; upd_taken = 1'b1;
    vpc = 64'h8000_0010;
    sample();
`ifdef BHT_UPDATE_BYPASS_EN
    check("hazard_valid0", int'(bht_valid[0]), 1);
    check("hazard_taken0", int'(bht_taken[0]), 1);
`else
    check("hazard_valid0", int'(bht_valid[0]), 0);
`endif
    advance();
    upd_valid = 1'b0;

    // Debug mode: update ignored, ghr stays 001
    debug_mode = 1'b1;
    upd_valid = 1'b1; upd_pc = 64'h8000_0020; upd_hist = 3'b001; upd_taken = 1'b1;
    step();
    debug_mode = 1'b0; upd_valid = 1'b0;
    vpc = 64'h8000_0020;          // 8 ^ 1 = row 9, same as the ignored update
    sample();
    check("debug_hist", int'(bht_hist), 1);
    check("debug_valid0", int'(bht_valid[0]), 0);
    advance();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      upd_valid  = ($urandom_range(0, 99) < 60);
      upd_taken  = 1'($urandom_range(0, 1));
      upd_pc     = {$urandom(), $urandom()};
      upd_hist   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(m_ghr);
      debug_mode = ($urandom_range(0, 19) == 0);
      flush_bht  = ($urandom_range(0, 499) == 0);
      vpc        = ($urandom_range(0, 1) == 1) ? upd_pc : {$urandom(), $urandom()};
      step();
    end
    upd_valid = 1'b0; debug_mode = 1'b0; flush_bht = 1'b0;

    // Reset in the middle of a flush
    flush_bht = 1'b1;
    step();
    flush_bht = 1'b0;
    repeat (10) step();
    rst_ni = 1'b0;
    model_clear();
    flush_left = 0;
    #1;
    check("rst_mid_flush_busy", int'(flush_busy), 0);
    check("rst_mid_flush_valid", int'(bht_valid), 0);
    check("rst_mid_flush_hist", int'(bht_hist), 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int r = 0; r < NR_ROWS; r++) begin
      vpc = 64'h8000_0000 | (64'(r) << 2);
      sample();
      check("rst_row_invalid", int'(bht_valid), 0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
